register_file: RTL and testbench

Integer register file for the SSRisc pipeline: 32 x XLEN architectural registers with two combinational read ports, one synchronous write port and a busy-bit scoreboard for long-latency producers such as loads. It sits between decode (read ports, stall request) and write-back (write port). The write port's one-hot row select comes from the existing `Decoder5x32`.

---
 rtl/register_file_pkg.sv | 7 +
 rtl/register_file_decoder.sv | 15 +
 rtl/register_file.sv | 82 ++++++++
 tb/tb_register_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared widths and constants for the SSRisc integer register file.
package register_file_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file_decoder.sv
// 5-to-32 one-hot decoder with enable; drives the write-port row select.
module Decoder5x32
  import register_file_pkg::*;
(
  input  logic [REG_AW-1:0]   in,
  input  logic                en,
  output logic [NUM_REGS-1:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/register_file.sv
// 31 x XLEN integer registers (x0 hardwired to zero), two combinational read
// ports with write-through bypass, one write port and a busy-bit scoreboard.
module register_file #(
  parameter int XLEN = register_file_pkg::XLEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [register_file_pkg::REG_AW-1:0] rs1_addr,
  input  logic [register_file_pkg::REG_AW-1:0] rs2_addr,
  input  logic                               rs1_used,
  input  logic                               rs2_used,
  output logic [XLEN-1:0]                    rs1_data,
  output logic [XLEN-1:0]                    rs2_data,
  input  logic                               wr_en,
  input  logic [register_file_pkg::REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]                    wr_data,
  input  logic                               claim_en,
  input  logic [register_file_pkg::REG_AW-1:0] claim_addr,
  output logic                               rs1_busy,
  output logic                               rs2_busy,
  output logic                               stall
);
  import register_file_pkg::*;

  localparam logic [NUM_REGS-1:0] ROW0_MASK = ~{{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]     regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] dec_out;
  logic [NUM_REGS-1:0] row_sel;
  logic [NUM_REGS-1:0] claim_sel;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rs1_hit;
  logic                rs2_hit;

  Decoder5x32 u_wr_dec (
    .in  (rd_addr),
    .en  (wr_en),
    .out (dec_out)
  );

  assign row_sel = dec_out & ROW0_MASK;

  always_comb begin
    claim_sel = '0;
    if (claim_en && (claim_addr != REG_ZERO)) claim_sel[claim_addr] = 1'b1;
  end

  // Clear before set: a claim in the same cycle belongs to a newer producer.
  assign busy_nxt = (busy & ~row_sel) | claim_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      busy <= busy_nxt & ROW0_MASK;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (row_sel[i]) regs[i] <= wr_data;
      end
    end
  end

  assign rs1_hit = wr_en && (rd_addr == rs1_addr);
  assign rs2_hit = wr_en && (rd_addr == rs2_addr);

  always_comb begin
    if (rs1_addr == REG_ZERO)  rs1_data = '0;
    else if (rs1_hit)          rs1_data = wr_data;
    else                       rs1_data = regs[rs1_addr];

    if (rs2_addr == REG_ZERO)  rs2_data = '0;
    else if (rs2_hit)          rs2_data = wr_data;
    else                       rs2_data = regs[rs2_addr];
  end

  // A same-cycle write-back resolves the hazard through the bypass.
  assign rs1_busy = busy[rs1_addr] & ~rs1_hit;
  assign rs2_busy = busy[rs2_addr] & ~rs2_hit;
  assign stall    = (rs1_busy & rs1_used) | (rs2_busy & rs2_used);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cycle table plus a
// model-driven random regression, both checked through an expectation queue.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, claim_addr = '0;
  logic        rs1_used = 1'b0, rs2_used = 1'b0, wr_en = 1'b0, claim_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, stall;

  register_file #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_used   (rs1_used),
    .rs2_used   (rs2_used),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .wr_en      (wr_en),
    .rd_addr    (rd_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr, rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used, chk;
    logic [31:0] d1, d2;
    logic        b1, b2, st;
  } vec_t;

  typedef struct {
    logic [31:0] d1, d2;
    logic        b1, b2, st;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] m_regs [0:31];
  logic        m_busy [0:31];

  function automatic vec_t row(bit r, bit we, int rd, logic [31:0] wd, bit ce, int ca,
                               int a1, int a2, bit u1, bit u2, bit ck,
                               logic [31:0] d1, logic [31:0] d2, bit b1, bit b2, bit st);
    vec_t v;
    v.rst = r;  v.wr_en = we;  v.rd_addr = rd[4:0];  v.wr_data = wd;
    v.claim_en = ce;  v.claim_addr = ca[4:0];
    v.rs1_addr = a1[4:0];  v.rs2_addr = a2[4:0];  v.rs1_used = u1;  v.rs2_used = u2;
    v.chk = ck;  v.d1 = d1;  v.d2 = d2;  v.b1 = b1;  v.b2 = b2;  v.st = st;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst;  wr_en = v.wr_en;  rd_addr = v.rd_addr;  wr_data = v.wr_data;
    claim_en = v.claim_en;  claim_addr = v.claim_addr;
    rs1_addr = v.rs1_addr;  rs2_addr = v.rs2_addr;
    rs1_used = v.rs1_used;  rs2_used = v.rs2_used;
  endtask

  // Sample at the falling edge, between the driven inputs and the next update.
  task automatic sample(string tag);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, " rs1_data"}, rs1_data, e.d1);
      chk({tag, " rs2_data"}, rs2_data, e.d2);
      chk({tag, " rs1_busy"}, {31'd0, rs1_busy}, {31'd0, e.b1});
      chk({tag, " rs2_busy"}, {31'd0, rs2_busy}, {31'd0, e.b2});
      chk({tag, " stall"},    {31'd0, stall},    {31'd0, e.st});
    end
  endtask

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && rd_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic m_rbusy(logic [4:0] a);
    return m_busy[a] && !(wr_en && rd_addr == a);
  endfunction

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    if ($urandom_range(0, 1) == 1) a = 5'($urandom_range(0, 7));
    else                           a = 5'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    exp_t e;
    logic b1, b2;

    tbl.push_back(row(1,0,0,32'h0,0,0, 0,0,0,0,0, 32'h0,32'h0,0,0,0));
    for (int i = 0; i < 32; i++)
      tbl.push_back(row(0,0,0,32'h0,0,0, i,31-i,1,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,1,0,32'hDEADBEEF,0,0, 0,0,1,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,0,1,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,1,5,32'h12345678,0,0, 5,6,1,1,1, 32'h12345678,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        5,6,1,1,1, 32'h12345678,32'h0,0,0,0));
    // load-use on x7
    tbl.push_back(row(0,0,0,32'h0,1,7,        0,7,0,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,7,0,1,1, 32'h0,32'h0,0,1,1));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,7,0,1,1, 32'h0,32'h0,0,1,1));
    tbl.push_back(row(0,1,7,32'hA5A5A5A5,0,0, 0,7,0,1,1, 32'h0,32'hA5A5A5A5,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,7,0,1,1, 32'h0,32'hA5A5A5A5,0,0,0));
    // busy but not used: no stall
    tbl.push_back(row(0,0,0,32'h0,1,8,        0,8,0,0,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,8,0,0,1, 32'h0,32'h0,0,1,0));
    tbl.push_back(row(0,1,8,32'h11,0,0,       0,8,0,0,1, 32'h0,32'h11,0,0,0));
    // set/clear collision on x9
    tbl.push_back(row(0,0,0,32'h0,1,9,        9,0,1,0,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,1,9,32'h99,1,9,       9,0,1,0,1, 32'h99,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        9,0,1,0,1, 32'h99,32'h0,1,0,1));
    tbl.push_back(row(0,1,9,32'h9A,0,0,       9,0,1,0,1, 32'h9A,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        9,9,1,1,1, 32'h9A,32'h9A,0,0,0));
    // claim x0, then reset on top of a claim and a write
    tbl.push_back(row(0,0,0,32'h0,1,0,        0,0,1,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        0,0,1,1,1, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,1,3,        3,5,1,1,1, 32'h0,32'h12345678,0,0,0));
    tbl.push_back(row(1,1,3,32'h33,0,0,       3,5,1,1,0, 32'h0,32'h0,0,0,0));
    tbl.push_back(row(0,0,0,32'h0,0,0,        3,5,1,1,1, 32'h0,32'h0,0,0,0));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      if (tbl[i].chk) begin
        e.d1 = tbl[i].d1;  e.d2 = tbl[i].d2;
        e.b1 = tbl[i].b1;  e.b2 = tbl[i].b2;  e.st = tbl[i].st;
        sbq.push_back(e);
        sample($sformatf("row%0d", i));
      end else begin
        @(negedge clk);
      end
      @(posedge clk); #1;
    end

    // Random regression against a reference model, starting from reset.
    rst = 1'b1;  wr_en = 1'b0;  claim_en = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_busy[r] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      wr_en      = ($urandom_range(0, 2) == 0);
      rd_addr    = rnd_addr();
      wr_data    = $urandom;
      claim_en   = ($urandom_range(0, 3) == 0);
      claim_addr = rnd_addr();
      rs1_addr   = rnd_addr();
      rs2_addr   = rnd_addr();
      rs1_used   = 1'($urandom_range(0, 1));
      rs2_used   = 1'($urandom_range(0, 1));

      b1 = m_rbusy(rs1_addr);
      b2 = m_rbusy(rs2_addr);
      e.d1 = m_read(rs1_addr);
      e.d2 = m_read(rs2_addr);
      e.b1 = b1;  e.b2 = b2;
      e.st = (b1 && rs1_used) || (b2 && rs2_used);
      sbq.push_back(e);
      sample($sformatf("rnd%0d", c));

      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[r] = 32'h0;
          m_busy[r] = 1'b0;
        end
      end else begin
        if (wr_en && rd_addr != 5'd0) begin
          m_regs[rd_addr] = wr_data;
          m_busy[rd_addr] = 1'b0;
        end
        if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
